// File: rtl/neuron_pkg.sv
// Shared fixed-point types, constants and helpers for the neuron datapath.
package neuron_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;
  localparam int PROD_W = 2 * DATA_W - FRAC_W;
  localparam int SAT_W  = 64;

  typedef logic signed [DATA_W-1:0] fx_t;

  localparam fx_t FX_MAX = 32'sh7FFF_FFFF;
  localparam fx_t FX_MIN = 32'sh8000_0000;

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } mac_state_e;

  // Clamp a wide signed value into the Q16.16 range.
  function automatic fx_t fx_sat(input logic signed [SAT_W-1:0] v);
    logic signed [SAT_W-1:0] max_w;
    logic signed [SAT_W-1:0] min_w;
    max_w = SAT_W'(FX_MAX);
    min_w = SAT_W'(FX_MIN);
    if (v > max_w) begin
      return FX_MAX;
    end else if (v < min_w) begin
      return FX_MIN;
    end else begin
      return fx_t'(v[DATA_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/fx_mul.sv
// Signed Q16.16 multiply; the arithmetic right shift truncates toward -inf.
module fx_mul
  import neuron_pkg::*;
(
  input  fx_t                      a,
  input  fx_t                      b,
  output logic signed [PROD_W-1:0] p
);

  logic signed [2*DATA_W-1:0] a_w_s;
  logic signed [2*DATA_W-1:0] b_w_s;
  logic signed [2*DATA_W-1:0] prod_s;

  assign a_w_s  = (2*DATA_W)'(a);
  assign b_w_s  = (2*DATA_W)'(b);
  assign prod_s = a_w_s * b_w_s;
  // The bits dropped by the cast are pure sign extension of the shifted product.
  assign p      = PROD_W'(prod_s >>> FRAC_W);

endmodule

// File: rtl/neuron_stream_mac.sv
// Streaming multiply-accumulate neuron: one weighted sample per cycle, one
// saturated Q16.16 result per N_IN-sample vector, runtime-loadable weights/bias.
module neuron_stream_mac
  import neuron_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int ACC_W = 2 * DATA_W - FRAC_W + $clog2(N_IN),
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_we,
  input  logic [IDX_W-1:0]  w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              busy
);

  mac_state_e               state_r;
  logic [IDX_W-1:0]         idx_r;
  logic signed [ACC_W-1:0]  acc_r;
  fx_t                      y_data_r;
  logic                     y_valid_r;
  logic                     x_ready_r;
  logic                     busy_r;
  fx_t                      w_r [N_IN];
  fx_t                      bias_r;

  fx_t                      w_sel_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  acc_sum_s;
  logic signed [SAT_W-1:0]  total_s;
  logic                     hs_s;
  logic                     last_s;

  // The weight read happens before any same-cycle write lands, so the old value is used.
  assign w_sel_s   = w_r[idx_r];
  assign acc_sum_s = acc_r + ACC_W'(prod_s);
  assign total_s   = SAT_W'(acc_sum_s) + SAT_W'(bias_r);
  assign hs_s      = x_valid & x_ready_r;
  assign last_s    = (idx_r == IDX_W'(N_IN - 1));

  assign x_ready = x_ready_r;
  assign y_valid = y_valid_r;
  assign y_data  = y_data_r;
  assign busy    = busy_r;

  fx_mul u_fx_mul (
    .a (x_data),
    .b (w_sel_s),
    .p (prod_s)
  );

  // Host-side weight and bias storage; both strobes may fire together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        w_r[i] <= 32'sd0;
      end
      bias_r <= 32'sd0;
    end else begin
      if (w_we) begin
        w_r[w_addr] <= fx_t'(w_data);
      end
      if (b_we) begin
        bias_r <= fx_t'(b_data);
      end
    end
  end

  // Accumulate/output state machine with all stream-facing outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_ACC;
      idx_r     <= '0;
      acc_r     <= '0;
      y_data_r  <= 32'sd0;
      y_valid_r <= 1'b0;
      x_ready_r <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (hs_s) begin
            busy_r <= 1'b1;
            if (last_s) begin
              y_data_r  <= fx_sat(total_s);
              acc_r     <= '0;
              idx_r     <= '0;
              state_r   <= ST_OUT;
              y_valid_r <= 1'b1;
              x_ready_r <= 1'b0;
            end else begin
              acc_r <= acc_sum_s;
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (y_ready) begin
            state_r   <= ST_ACC;
            y_valid_r <= 1'b0;
            x_ready_r <= 1'b1;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_ACC;
          idx_r     <= '0;
          acc_r     <= '0;
          y_valid_r <= 1'b0;
          x_ready_r <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_stream_mac.sv
// Scoreboard bench for neuron_stream_mac: a driver feeds samples and weight/bias
// writes, an arithmetic reference model queues expected results, and an
// independent monitor pops and compares on every output handshake.
module tb_neuron_stream_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_we = 1'b0;
  logic [2:0]  w_addr = 3'd0;
  logic [31:0] w_data = 32'd0;
  logic        b_we = 1'b0;
  logic [31:0] b_data = 32'd0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [31:0] x_data = 32'd0;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic [31:0] y_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int final_cyc = -10;
  int yr_mode = 1;     // 0: hold low, 1: always ready, 2: random
  int n_push = 0;
  int n_out = 0;
  logic [31:0] last_y = 32'd0;

  // reference model state
  logic signed [31:0] m_w [8];
  logic signed [31:0] m_b;
  int                 m_idx;
  longint             m_sum;
  int                 m_vec;
  logic [31:0]        exp_q [$];
  logic [31:0]        vx [8];

  neuron_stream_mac dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_data(b_data), .x_valid(x_valid), .x_ready(x_ready),
    .x_data(x_data), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_sat(input longint v);
    longint hi;
    longint lo;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    if (v > hi) return 32'h7FFF_FFFF;
    if (v < lo) return 32'h8000_0000;
    return v[31:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_w[i] = 32'sd0;
    m_b = 32'sd0;
    m_idx = 0;
    m_sum = 0;
    exp_q.delete();
  endtask

  // one accepted sample: real-valued product floored to Q16.16, summed, biased, clamped
  task automatic model_sample(input logic [31:0] xd);
    longint p;
    p = (longint'($signed(xd)) * longint'(m_w[m_idx])) >>> 16;
    if (m_idx == 7) begin
      exp_q.push_back(m_sat(m_sum + p + longint'(m_b)));
      n_push++;
      m_vec++;
      m_sum = 0;
      m_idx = 0;
      final_cyc = cyc + 1;
    end else begin
      m_sum = m_sum + p;
      m_idx++;
    end
  endtask

  // drive one cycle of inputs; hs reports whether the sample is taken at the next edge
  task automatic step(input bit xv, input logic [31:0] xd, input bit wwe, input logic [2:0] wa,
                      input logic [31:0] wd, input bit bwe, input logic [31:0] bd, output bit hs);
    @(posedge clk);
    #1;
    x_valid = xv; x_data = xd;
    w_we = wwe; w_addr = wa; w_data = wd;
    b_we = bwe; b_data = bd;
    y_ready = (yr_mode == 0) ? 1'b0 : (yr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    hs = xv && x_ready;
    if (hs) model_sample(xd);
    if (wwe) m_w[wa] = wd;
    if (bwe) m_b = bd;
  endtask

  task automatic idle(input int n);
    bit hs;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0, hs);
  endtask

  task automatic send_x(input logic [31:0] xd, input bit wwe, input logic [2:0] wa,
                        input logic [31:0] wd, input bit bwe, input logic [31:0] bd);
    bit hs;
    int tries;
    tries = 0;
    hs = 1'b0;
    while (!hs && tries < 100) begin
      step(1'b1, xd, wwe, wa, wd, bwe, bd, hs);
      tries++;
    end
    if (!hs) chk("x_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_vec();
    for (int k = 0; k < 8; k++) send_x(vx[k], 1'b0, 3'd0, 32'd0, 1'b0, 32'd0);
    idle(1);
  endtask

  task automatic load_w(input logic [31:0] v);
    bit hs;
    for (int k = 0; k < 8; k++) step(1'b0, 32'd0, 1'b1, 3'(k), v, 1'b0, 32'd0, hs);
  endtask

  task automatic load_b(input logic [31:0] v);
    bit hs;
    step(1'b0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, v, hs);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      idle(1);
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    x_valid = 1'b0; w_we = 1'b0; b_we = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_x_ready", 32'(x_ready), 32'd1);
    chk("rst_y_data", y_data, 32'd0);
  endtask

  function automatic logic [31:0] rnd_fx();
    int s;
    case ($urandom_range(0, 3))
      0: return $urandom();
      3: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_0000 : 32'h8000_0000;
      default: begin
        s = int'($urandom_range(0, 32'h60000)) - 32'sh30000;
        return 32'(s);
      end
    endcase
  endfunction

  // monitor: latency, hold-while-stalled, and scoreboard pop on each y handshake
  initial begin : monitor
    bit held;
    logic [31:0] held_data;
    held = 1'b0;
    held_data = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else if (y_valid) begin
        if (!held) begin
          chk("y_latency", 32'(cyc), 32'(final_cyc));
          held_data = y_data;
        end else begin
          chk("y_hold", y_data, held_data);
        end
        chk("x_ready_in_out", 32'(x_ready), 32'd0);
        if (y_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_y", y_data, 32'hDEAD_BEEF);
          end else begin
            chk("y_data", y_data, exp_q.pop_front());
          end
          last_y = y_data;
          n_out++;
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : driver
    bit hs;
    int steps;
    int target;
    m_vec = 0;
    model_clear();
    do_reset();

    // zero weights after reset
    for (int k = 0; k < 8; k++) vx[k] = 32'h0001_0000;
    send_vec();
    drain();
    chk("zero_weights", last_y, 32'h0000_0000);

    // basic sum 0..7 with bias 0.5
    load_w(32'h0001_0000);
    load_b(32'h0000_8000);
    for (int k = 0; k < 8; k++) vx[k] = 32'(k) << 16;
    send_vec();
    drain();
    chk("basic_sum", last_y, 32'h001C_8000);

    // backpressure, then a back-to-back vector
    yr_mode = 0;
    send_vec();
    idle(6);
    yr_mode = 1;
    for (int k = 0; k < 8; k++) vx[k] = 32'(7 - k) << 16;
    for (int k = 0; k < 8; k++) send_x(vx[k], 1'b0, 3'd0, 32'd0, 1'b0, 32'd0);
    idle(1);
    drain();
    chk("after_backpressure", last_y, 32'h001C_8000);

    // saturation, positive and negative
    load_b(32'd0);
    load_w(32'h7FFF_0000);
    for (int k = 0; k < 8; k++) vx[k] = 32'h7FFF_0000;
    send_vec();
    drain();
    chk("sat_pos", last_y, 32'h7FFF_FFFF);
    for (int k = 0; k < 8; k++) vx[k] = 32'h8000_0000;
    send_vec();
    drain();
    chk("sat_neg", last_y, 32'h8000_0000);

    // fractional truncation with only w0 non-zero
    load_w(32'd0);
    load_b(32'd0);
    step(1'b0, 32'd0, 1'b1, 3'd0, 32'h0000_8000, 1'b0, 32'd0, hs);
    for (int k = 0; k < 8; k++) vx[k] = 32'd0;
    vx[0] = 32'hFFFE_8000; send_vec(); drain();
    chk("frac_neg", last_y, 32'hFFFF_4000);
    vx[0] = 32'h0000_0001; send_vec(); drain();
    chk("frac_tiny_pos", last_y, 32'h0000_0000);
    vx[0] = 32'hFFFF_FFFF; send_vec(); drain();
    chk("frac_tiny_neg", last_y, 32'hFFFF_FFFF);

    // same-cycle w0 write on x0 and bias write on x7: old values used
    send_x(32'h0001_0000, 1'b1, 3'd0, 32'h0002_0000, 1'b0, 32'd0);
    for (int k = 1; k < 8; k++)
      send_x(32'd0, 1'b0, 3'd0, 32'd0, (k == 7), 32'h0001_0000);
    idle(1);
    drain();
    chk("old_w0_old_bias", last_y, 32'h0000_8000);
    vx[0] = 32'h0001_0000; send_vec(); drain();
    chk("new_w0_new_bias", last_y, 32'h0003_0000);

    // reset mid-vector
    load_w(32'h0001_0000);
    for (int k = 0; k < 3; k++) send_x(32'h0001_0000, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0);
    idle(1);
    @(negedge clk);
    chk("busy_mid_vector", 32'(busy), 32'd1);
    do_reset();
    for (int k = 0; k < 8; k++) vx[k] = 32'h0001_0000;
    send_vec();
    drain();
    chk("post_reset_zero", last_y, 32'h0000_0000);
    load_w(32'h0001_0000);
    for (int k = 0; k < 8; k++) vx[k] = 32'(k) << 16;
    send_vec();
    drain();
    chk("post_reset_sum", last_y, 32'h001C_0000);

    // randomized traffic with random writes and backpressure
    yr_mode = 2;
    target = m_vec + 30;
    steps = 0;
    while (m_vec < target && steps < 4000) begin
      step(($urandom_range(0, 3) != 0), rnd_fx(),
           ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), rnd_fx(),
           ($urandom_range(0, 9) == 0), rnd_fx(), hs);
      steps++;
    end
    chk("random_vectors_done", 32'(m_vec), 32'(target));
    yr_mode = 1;
    idle(1);
    drain();
    chk("output_count", 32'(n_out), 32'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
